// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: SPI responder modelling an MCP4922-style dual DAC.
// Receives 16-bit command frames over an asynchronous mode-0 SPI link. Each
// frame is decoded into a per-channel input register. On the latch strobe,
// both input registers move to the output registers.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   spi_sclk     SPI clock (async, mode 0)
//   spi_csn      chip select, active-low (async)
//   spi_mosi     serial data, MSB first (async)
//   latchn       DAC latch strobe, active-low (async)
//   chan_a/b     latched channel codes (0 while the channel is shut down)
//   shdn_a/b     latched channel shutdown flags
//   frame_valid  one-clk pulse when a frame with exactly FRAME_BITS bits ends
//   frame_err    one-clk pulse when a frame ends with any other bit count
//   busy         synchronized chip select is low
//
// Optional build macro DAC_RX_FRAME_COUNT_EN adds two ports:
//   frame_count  16-bit wrapping count of good frames
//   err_count    8-bit saturating count of bad frames
module dac_spi_receiver #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  input  logic              latchn,
  output logic [DATA_W-1:0] chan_a,
  output logic [DATA_W-1:0] chan_b,
  output logic              shdn_a,
  output logic              shdn_b,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy
`ifdef DAC_RX_FRAME_COUNT_EN
  ,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 2);
  localparam int unsigned CHAN_BIT = FRAME_BITS - 1;
  localparam int unsigned SHDN_BIT = 12;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Synchronizer chains; reset to the idle bus levels.
  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync, latchn_sync;
  logic                   sclk_d, csn_d, latchn_d;
  // Fills with ones after reset; once full, the csn chain holds real pin samples.
  logic [SYNC_STAGES:0]   warm;
  logic                   armed;

  logic sclk_s, csn_s, mosi_s, latchn_s;
  logic sclk_rise, csn_rise, csn_fall, latch_fall;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_W-1:0]       in_a, in_b;
  logic                    pend_shdn_a, pend_shdn_b;

  logic [DATA_W-1:0]       in_a_nxt, in_b_nxt;
  logic                    pend_shdn_a_nxt, pend_shdn_b_nxt;
  logic                    frame_good;

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign latchn_s = latchn_sync[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign csn_rise   = csn_s & ~csn_d;
  assign csn_fall   = ~csn_s & csn_d;
  assign latch_fall = ~latchn_s & latchn_d;

  assign frame_good = (bit_cnt == CNT_FULL);

  // Input synchronizers, edge-detect flops and post-reset arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync   <= '0;
      csn_sync    <= '1;
      mosi_sync   <= '0;
      latchn_sync <= '1;
      sclk_d      <= 1'b0;
      csn_d       <= 1'b1;
      latchn_d    <= 1'b1;
      warm        <= '0;
      armed       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      csn_sync    <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      latchn_sync <= {latchn_sync[SYNC_STAGES-2:0], latchn};
      sclk_d      <= sclk_s;
      csn_d       <= csn_s;
      latchn_d    <= latchn_s;
      warm        <= {warm[SYNC_STAGES-1:0], 1'b1};
      // A frame already running when reset releases is skipped: csn must be
      // seen high before the next falling edge can start a frame.
      armed       <= armed | (warm[SYNC_STAGES] & csn_s);
      busy        <= ~csn_s;
    end
  end

  // Frame decode into the selected channel's input register.
  always_comb begin
    in_a_nxt        = in_a;
    in_b_nxt        = in_b;
    pend_shdn_a_nxt = pend_shdn_a;
    pend_shdn_b_nxt = pend_shdn_b;
    if (state == ST_DONE && frame_good) begin
      if (shift_reg[CHAN_BIT]) begin
        in_b_nxt        = shift_reg[DATA_W-1:0];
        pend_shdn_b_nxt = ~shift_reg[SHDN_BIT];
      end else begin
        in_a_nxt        = shift_reg[DATA_W-1:0];
        pend_shdn_a_nxt = ~shift_reg[SHDN_BIT];
      end
    end
  end

  // Frame FSM, input registers and latched outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      in_a        <= '0;
      in_b        <= '0;
      pend_shdn_a <= 1'b1;
      pend_shdn_b <= 1'b1;
      chan_a      <= '0;
      chan_b      <= '0;
      shdn_a      <= 1'b1;
      shdn_b      <= 1'b1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef DAC_RX_FRAME_COUNT_EN
      frame_count <= '0;
      err_count   <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      in_a        <= in_a_nxt;
      in_b        <= in_b_nxt;
      pend_shdn_a <= pend_shdn_a_nxt;
      pend_shdn_b <= pend_shdn_b_nxt;

      case (state)
        ST_IDLE: begin
          if (csn_fall && armed) begin
            state     <= ST_SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (csn_rise) begin
            state <= ST_DONE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          frame_valid <= frame_good;
          frame_err   <= ~frame_good;
`ifdef DAC_RX_FRAME_COUNT_EN
          if (frame_good) begin
            frame_count <= frame_count + 16'd1;
          end else if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase

      // Latch copies the post-decode values so a same-cycle frame is included.
      if (latch_fall) begin
        chan_a <= pend_shdn_a_nxt ? '0 : in_a_nxt;
        chan_b <= pend_shdn_b_nxt ? '0 : in_b_nxt;
        shdn_a <= pend_shdn_a_nxt;
        shdn_b <= pend_shdn_b_nxt;
      end
    end
  end

endmodule
